// File: rtl/chaos_rng_wb_reader.sv
// chaos_rng_wb_reader
// Consumer end of the chaos generator. It samples the x/y/z state words every
// DECIM clocks and takes one bit per sample (parity of the three LSBs). It packs
// 32 bits per word and buffers the words in a FIFO. The management SoC reads the
// words over a Wishbone slave port.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   x_i, y_i, z_i       chaos state words
//   wbs_*_i             Wishbone slave request (stb, cyc, we, sel, dat, adr)
//   wbs_ack_o           registered one-cycle acknowledge
//   wbs_dat_o           read data, valid only while wbs_ack_o is high
//   irq_o               high while enabled and FIFO count >= IRQ_THRESH
//
// Register map (offset from ADDR_BASE, decoded on adr[31:4])
//   0x0 CTRL   [0] enable (RW), [1] clear (write-1, reads 0); needs sel[0]
//   0x4 STATUS [0] empty [1] full [2] overflow [3] underflow [15:8] count
//   0x8 DATA   read pops the head word; empty read returns 0, sets underflow
//   0xC        reads 0, writes ignored
//
// Handshake: a request is accepted on the edge where hit=1 and ack is low.
// Every side effect lands on that same edge and ack rises. Because an accepted
// request always raises ack, a master that drops stb/cyc early still gets its
// pop or write. A request held over the ack cycle is accepted again one cycle
// later.
module chaos_rng_wb_reader #(
   parameter int unsigned DECIM      = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned IRQ_THRESH = 4,
   parameter logic [31:0] ADDR_BASE  = 32'h3000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] x_i,
   input  logic [31:0] y_i,
   input  logic [31:0] z_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        irq_o
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;

   logic          enable_q, enable_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic [DW-1:0] decim_q, decim_d;
   logic [4:0]    bit_cnt_q, bit_cnt_d;
   logic [31:0]   pack_q, pack_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ack_q, ack_d;
   logic [31:0]   dat_q, dat_d;
   logic          irq_q, irq_d;
   logic [31:0]   mem_q [FIFO_DEPTH];

   logic        hit, req, empty, full;
   logic        ctrl_wr, clear, data_rd, pop, udf_set;
   logic        sample, smp_bit, word_done, push, ovf_set, mem_we;
   logic [31:0] word, rdata;
   logic        unused_ok;

   assign unused_ok = ^{x_i[31:1], y_i[31:1], z_i[31:1], wbs_sel_i[3:1],
                        wbs_dat_i[31:2], wbs_adr_i[1:0]};

   always_comb begin
      hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
      req     = hit & ~ack_q;
      empty   = (count_q == '0);
      full    = (count_q == CW'(FIFO_DEPTH));
      ctrl_wr = req & wbs_we_i & (wbs_adr_i[3:2] == 2'd0) & wbs_sel_i[0];
      clear   = ctrl_wr & wbs_dat_i[1];
      data_rd = req & ~wbs_we_i & (wbs_adr_i[3:2] == 2'd2);
      pop     = data_rd & ~empty;
      udf_set = data_rd & empty;

      sample    = enable_q & (decim_q == DW'(DECIM - 1));
      smp_bit   = x_i[0] ^ y_i[0] ^ z_i[0];
      word      = {pack_q[30:0], smp_bit};
      word_done = sample & (bit_cnt_q == 5'd31);
      // A pop on the same edge frees the slot, so a full FIFO still accepts.
      push      = word_done & (~full | pop);
      ovf_set   = word_done & full & ~pop;
      mem_we    = push & ~clear;

      rdata = 32'h0;
      unique case (wbs_adr_i[3:2])
         2'd0: rdata = {31'h0, enable_q};
         2'd1: rdata = {16'h0, 8'(count_q), 4'h0, udf_q, ovf_q, full, empty};
         2'd2: rdata = empty ? 32'h0 : mem_q[rd_ptr_q];
         default: rdata = 32'h0;
      endcase
   end

   always_comb begin
      enable_d  = enable_q;
      ovf_d     = ovf_q;
      udf_d     = udf_q;
      decim_d   = decim_q;
      bit_cnt_d = bit_cnt_q;
      pack_d    = pack_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;

      if (sample) begin
         decim_d   = '0;
         pack_d    = word;
         bit_cnt_d = bit_cnt_q + 5'd1;
      end else if (enable_q) begin
         decim_d = decim_q + DW'(1);
      end

      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (push & ~pop) count_d = count_q + CW'(1);
      if (pop & ~push) count_d = count_q - CW'(1);

      if (ovf_set) ovf_d = 1'b1;
      if (udf_set) udf_d = 1'b1;
      if (ctrl_wr) enable_d = wbs_dat_i[0];

      // Clear wins over everything in flight, including a completing word.
      if (clear) begin
         decim_d   = '0;
         bit_cnt_d = '0;
         pack_d    = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         ovf_d     = 1'b0;
         udf_d     = 1'b0;
      end

      ack_d = req;
      dat_d = (req & ~wbs_we_i) ? rdata : 32'h0;
      irq_d = enable_q & (32'(count_q) >= IRQ_THRESH);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         enable_q  <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         decim_q   <= '0;
         bit_cnt_q <= '0;
         pack_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
         irq_q     <= 1'b0;
      end else begin
         enable_q  <= enable_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         decim_q   <= decim_d;
         bit_cnt_q <= bit_cnt_d;
         pack_q    <= pack_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         irq_q     <= irq_d;
      end
   end

   // Storage needs no reset; the count and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (rst && mem_we) mem_q[wr_ptr_q] <= word;
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_chaos_rng_wb_reader.sv
// Bench for chaos_rng_wb_reader. A behavioural model advances one clock at a
// time. It keeps the FIFO as a queue of words, the partial word as a bit
// count, and the sample phase as an integer. Each accepted request pushes its
// expected read data onto exp_q. A monitor pops exp_q whenever the DUT acks,
// and it checks ack/irq against the model every cycle.
module tb_chaos_rng_wb_reader;

   localparam int unsigned DECIM      = 4;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned IRQ_THRESH = 4;
   localparam logic [31:0] BASE       = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] x_i = '0, y_i = '0, z_i = '0;
   logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
   logic [3:0]  wbs_sel_i = 4'hF;
   logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0;
   logic        wbs_ack_o, irq_o;
   logic [31:0] wbs_dat_o;

   int checks = 0;
   int fails  = 0;
   bit rand_xyz = 1'b0;

   chaos_rng_wb_reader #(
      .DECIM(DECIM), .FIFO_DEPTH(FIFO_DEPTH), .IRQ_THRESH(IRQ_THRESH), .ADDR_BASE(BASE)
   ) dut (
      .clk(clk), .rst(rst), .x_i(x_i), .y_i(y_i), .z_i(z_i),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .irq_o(irq_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0] exp_q[$];
   logic [31:0] m_fifo[$];
   bit          m_en = 0, m_ovf = 0, m_udf = 0, m_ack = 0, m_irq = 0;
   int          m_phase = 0, m_nbits = 0;
   logic [31:0] m_pack = '0;

   bit          m_req, m_have, m_pop, m_udfs, m_ctrl, m_clr, m_new_irq, m_b;
   logic [31:0] m_rdata, m_word;
   int          m_size;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst) begin
            m_en = 0; m_ovf = 0; m_udf = 0; m_ack = 0; m_irq = 0;
            m_phase = 0; m_nbits = 0; m_pack = '0;
            m_fifo.delete();
         end else begin
            m_size    = m_fifo.size();
            m_req     = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE[31:4]) && !m_ack;
            m_new_irq = m_en && (m_size >= IRQ_THRESH);
            m_rdata   = '0;
            if (m_req && !wbs_we_i) begin
               case (wbs_adr_i[3:2])
                  2'd0: m_rdata = {31'h0, m_en};
                  2'd1: m_rdata = {16'h0, 8'(m_size), 4'h0, m_udf, m_ovf,
                                   m_size == FIFO_DEPTH, m_size == 0};
                  2'd2: m_rdata = (m_size > 0) ? m_fifo[0] : 32'h0;
                  default: m_rdata = '0;
               endcase
            end
            if (m_req) exp_q.push_back(m_rdata);

            m_have = 0;
            if (m_en) begin
               if (m_phase == DECIM - 1) begin
                  m_phase = 0;
                  m_b     = x_i[0] ^ y_i[0] ^ z_i[0];
                  m_pack  = {m_pack[30:0], m_b};
                  m_nbits = m_nbits + 1;
                  if (m_nbits == 32) begin
                     m_have  = 1;
                     m_word  = m_pack;
                     m_nbits = 0;
                  end
               end else begin
                  m_phase = m_phase + 1;
               end
            end

            m_pop  = m_req && !wbs_we_i && wbs_adr_i[3:2] == 2'd2 && m_size > 0;
            m_udfs = m_req && !wbs_we_i && wbs_adr_i[3:2] == 2'd2 && m_size == 0;
            m_ctrl = m_req && wbs_we_i && wbs_adr_i[3:2] == 2'd0 && wbs_sel_i[0];
            m_clr  = m_ctrl && wbs_dat_i[1];

            if (m_clr) begin
               m_fifo.delete();
               m_pack = '0; m_nbits = 0; m_phase = 0; m_ovf = 0; m_udf = 0;
            end else begin
               if (m_pop) void'(m_fifo.pop_front());
               if (m_have) begin
                  if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(m_word);
                  else m_ovf = 1;
               end
               if (m_udfs) m_udf = 1;
            end
            if (m_ctrl) m_en = wbs_dat_i[0];
            m_ack = m_req;
            m_irq = m_new_irq;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [31:0] mon_exp;
   initial begin
      forever begin
         @(negedge clk);
         checks++;
         if (wbs_ack_o !== m_ack) begin
            fails++;
            $display("FAIL ack t=%0t got=%b want=%b", $time, wbs_ack_o, m_ack);
         end
         checks++;
         if (irq_o !== m_irq) begin
            fails++;
            $display("FAIL irq t=%0t got=%b want=%b", $time, irq_o, m_irq);
         end
         if (wbs_ack_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL rdata_unexpected t=%0t got=%h want=<none>", $time, wbs_dat_o);
            end else begin
               mon_exp = exp_q.pop_front();
               if (wbs_dat_o !== mon_exp) begin
                  fails++;
                  $display("FAIL rdata t=%0t got=%h want=%h", $time, wbs_dat_o, mon_exp);
               end
            end
         end else begin
            checks++;
            if (wbs_dat_o !== 32'h0) begin
               fails++;
               $display("FAIL dat_idle t=%0t got=%h want=00000000", $time, wbs_dat_o);
            end
         end
      end
   end

   // Background chaos words for the randomized phase.
   initial begin
      forever begin
         @(negedge clk);
         if (rand_xyz) begin
            x_i = $urandom; y_i = $urandom; z_i = $urandom;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_const(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [3:0] off, input logic [31:0] wdat,
                          input logic [3:0] sel, output logic [31:0] rdat);
      bit got;
      @(negedge clk);
      wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = we; wbs_sel_i = sel;
      wbs_dat_i = wdat; wbs_adr_i = BASE | {28'h0, off};
      got  = 0;
      rdat = '0;
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge clk);
         if (wbs_ack_o) begin
            got  = 1;
            rdat = wbs_dat_o;
         end
      end
      wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
      checks++;
      if (!got) begin
         fails++;
         $display("FAIL ack_timeout off=%h got=no_ack want=ack", off);
      end
   endtask

   task automatic wb_hold(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          input logic [3:0] sel, input int n);
      @(negedge clk);
      wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = we; wbs_sel_i = sel;
      wbs_dat_i = wdat; wbs_adr_i = adr;
      repeat (n) @(negedge clk);
      wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] rd;
   int          op;
   initial begin
      idle(3);
      rst = 1;
      idle(2);
      wb_xfer(0, 4'h4, 0, 4'hF, rd);
      check_const("reset_status", rd, 32'h0000_0001);

      // Constant-one bit stream.
      x_i = 32'h1; y_i = 32'h0; z_i = 32'h0;
      wb_xfer(1, 4'h0, 32'h1, 4'hF, rd);
      idle(32 * DECIM + 2);
      wb_xfer(1, 4'h0, 32'h0, 4'hF, rd);
      wb_xfer(0, 4'h4, 0, 4'hF, rd);
      check_const("ones_status_before", rd, 32'h0000_0100);
      wb_xfer(0, 4'h8, 0, 4'hF, rd);
      check_const("ones_data", rd, 32'hFFFF_FFFF);
      wb_xfer(0, 4'h4, 0, 4'hF, rd);
      check_const("ones_status_after", rd, 32'h0000_0001);

      // Alternating bit stream starting with 1.
      wb_xfer(1, 4'h0, 32'h2, 4'hF, rd);
      wb_xfer(1, 4'h0, 32'h1, 4'hF, rd);
      for (int i = 0; i < 32; i++) begin
         x_i = (i % 2 == 0) ? 32'h1 : 32'h0;
         idle(DECIM);
      end
      wb_xfer(1, 4'h0, 32'h0, 4'hF, rd);
      wb_xfer(0, 4'h8, 0, 4'hF, rd);
      check_const("alt_data", rd, 32'hAAAA_AAAA);

      // Overflow: nine words with no reads, then drain and underflow.
      rand_xyz = 1;
      wb_xfer(1, 4'h0, 32'h3, 4'hF, rd);
      idle(9 * 32 * DECIM + 20);
      wb_xfer(1, 4'h0, 32'h0, 4'hF, rd);
      wb_xfer(0, 4'h4, 0, 4'hF, rd);
      check_const("full_status", rd, 32'h0000_0806);
      for (int i = 0; i < FIFO_DEPTH; i++) wb_xfer(0, 4'h8, 0, 4'hF, rd);
      wb_xfer(0, 4'h8, 0, 4'hF, rd);
      check_const("empty_data", rd, 32'h0);
      wb_xfer(0, 4'h4, 0, 4'hF, rd);
      check_const("udf_status", rd, 32'h0000_000D);
      wb_xfer(1, 4'h0, 32'h3, 4'hF, rd);
      wb_xfer(0, 4'h4, 0, 4'hF, rd);
      check_const("clear_status", rd, 32'h0000_0001);

      // Reset while a DATA read with three words buffered is pending.
      rand_xyz = 0;
      x_i = 32'h1; y_i = 32'h0; z_i = 32'h0;
      wb_xfer(1, 4'h0, 32'h3, 4'hF, rd);
      idle(3 * 32 * DECIM + 2);
      wb_xfer(1, 4'h0, 32'h0, 4'hF, rd);
      wb_xfer(0, 4'h4, 0, 4'hF, rd);
      check_const("three_status", rd, 32'h0000_0300);
      @(negedge clk);
      wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = BASE | 32'h8;
      rst = 0;
      @(negedge clk);
      check_const("rst_no_ack", {31'h0, wbs_ack_o}, 32'h0);
      wbs_stb_i = 0; wbs_cyc_i = 0;
      rst = 1;
      wb_xfer(0, 4'h4, 0, 4'hF, rd);
      check_const("rst_status", rd, 32'h0000_0001);

      // Randomized traffic.
      rand_xyz = 1;
      wb_xfer(1, 4'h0, 32'h1, 4'hF, rd);
      for (int n = 0; n < 120; n++) begin
         op = $urandom_range(0, 9);
         case (op)
            0, 1, 2, 3: wb_xfer(0, 4'h8, 0, 4'hF, rd);
            4, 5:       wb_xfer(0, 4'h4, 0, 4'hF, rd);
            6:          wb_xfer(0, 4'h0, 0, 4'hF, rd);
            7: wb_xfer(1, 4'h0, {30'h0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0)},
                       4'($urandom_range(0, 15)), rd);
            8: wb_hold(1'($urandom_range(0, 1)), BASE | {28'h0, 2'($urandom_range(1, 3)), 2'b00},
                       $urandom & 32'hFFFF_FFFC, 4'hF, $urandom_range(2, 4));
            default: wb_hold(1'($urandom_range(0, 1)), BASE ^ 32'h0000_0100, 32'h3, 4'hF,
                             $urandom_range(1, 3));
         endcase
         idle($urandom_range(0, 80));
      end
      idle(4);
      check_const("exp_q_drained", exp_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
